// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a small FIFO over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W  = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [FC_W-1:0]  FULL_CNT = FC_W'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [7:0]         head;

    state_t             state, state_n;
    logic [CNT_W-1:0]   baud_cnt, baud_cnt_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic [7:0]         shift, shift_n;
    logic               tx_n;
    logic               baud_end;
`ifdef UART_TX_PARITY_EN
    logic               parity, parity_n;
`endif

    // Full/empty come only from the registered count, so tx_ready never depends on a same-cycle pop.
    assign tx_ready      = (fifo_count != FULL_CNT);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign head          = mem[rd_ptr];
    assign busy          = (state != IDLE) || fifo_nonempty;
    assign baud_end      = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity;
`endif
        case (state)
            IDLE: begin
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                if (fifo_nonempty) begin
                    shift_n = head;
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^head;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = parity;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        tx_n = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    tx_n       = 1'b1;
                    state_n    = STOP;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (fifo_nonempty) begin
                        shift_n = head;
                        pop     = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_n = ^head;
`endif
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                state_n    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            tx       <= tx_n;
        end
    end

    // Payload registers carry no reset; they are always reloaded before being shifted out.
    always_ff @(posedge clk) begin
        shift <= shift_n;
`ifdef UART_TX_PARITY_EN
        parity <= parity_n;
`endif
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a serial-receiver scoreboard for uart_tx_fifo (DIV=16).
// Also exercises the UART_TX_PARITY_EN build when that macro is defined.
module tb_uart_tx_fifo;

    localparam int BIT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB      = 11;
    localparam int NFRAMES = 19;
`else
    localparam int FB      = 10;
    localparam int NFRAMES = 17;
`endif
    localparam int FRAME = FB * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_frames = 0;
    int ready_err = 0;
    int max_cnt = 0;
    int t_first = 0;
    int t_done = 0;
    bit seen = 1'b0;
    logic last_parity = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.CLK_FREQ(1600), .BAUD(100), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold tx_valid high with byte b until the handshake completes; the byte is then expected on the line.
    task automatic push_byte(input logic [7:0] b, output int waited);
        bit acc;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 400) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = b;
            acc = tx_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(b);
            else waited++;
        end
        if (!acc) check("push_accept", 0, 1);
    endtask

    task automatic release_valid();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_low(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 400);
        check(name, int'(tx), 0);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < bound);
        check(name, int'(busy), 0);
        #1;
    endtask

    task automatic rx_wait(input int n, inout bit ok);
        for (int k = 0; k < n; k++) begin
            if (!ok) return;
            @(negedge clk);
            if (rst_n !== 1'b1) ok = 1'b0;
        end
    endtask

    // Serial receiver: samples mid-bit and checks each decoded frame against the expected queue.
    initial begin
        logic [7:0] d;
        logic [7:0] e;
        logic s0, sp, par;
        bit ok;
        d = '0; e = '0; s0 = 1'b0; sp = 1'b0; par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ok = 1'b1;
                rx_wait(BIT / 2, ok);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    rx_wait(BIT, ok);
                    d[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                rx_wait(BIT, ok);
                par = tx;
`endif
                rx_wait(BIT, ok);
                sp = tx;
                if (ok) begin
                    rx_frames++;
                    check("rx_start", int'(s0), 0);
                    check("rx_stop", int'(sp), 1);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", int'(d), int'(e));
`ifdef UART_TX_PARITY_EN
                        last_parity = par;
                        check("rx_parity", int'(par), int'(^e));
`endif
                    end
                end
            end
        end
    end

    // Line watchers: ready/count consistency, peak occupancy, first start edge to busy falling.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (tx_ready !== (fifo_count != 3'd4)) ready_err++;
                if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            end
            if (!seen && rst_n === 1'b1 && tx === 1'b0) begin
                seen = 1'b1;
                t_first = cyc;
            end else if (seen && busy === 1'b0) begin
                seen = 1'b0;
                t_done = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [7:0] hello [6];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
        hello[3] = 8'h4C; hello[4] = 8'h4F; hello[5] = 8'h0D;

        #3 rst_n = 1'b0;
        #30;
        check("rst_tx", int'(tx), 1);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte 0x55 with exact start latency and frame length.
        push_byte(8'h55, w);
        release_valid();
        check("t1_count_queued", int'(fifo_count), 1);
        check("t1_tx_before", int'(tx), 1);
        @(negedge clk);
        check("t1_start_low", int'(tx), 0);
        check("t1_count_popped", int'(fifo_count), 0);
        check("t1_busy", int'(busy), 1);
        wait_idle("t1_idle", 400);
        check("t1_frame_len", t_done - t_first, FRAME);

        // Burst "HELLO\r" with tx_valid held high throughout.
        for (int i = 0; i < 6; i++) begin
            push_byte(hello[i], w);
            if (i == 5) check("t2_backpressure", int'(w > 0), 1);
        end
        release_valid();
        wait_idle("t2_idle", 2000);
        check("t2_total_len", t_done - t_first, 6 * FRAME);

        // Fill the FIFO behind a frame in flight, then offer 0xAA while full.
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        push_byte(8'h33, w);
        push_byte(8'h44, w);
        push_byte(8'h66, w);
        @(negedge clk);
        tx_data = 8'hAA;
        check("t3_full_ready", int'(tx_ready), 0);
        check("t3_full_count", int'(fifo_count), 4);
        push_byte(8'hAA, w);
        check("t3_waited", int'(w > 100), 1);
        release_valid();
        check("t3_count_after", int'(fifo_count), 4);
        wait_idle("t3_idle", 2000);

        // Push on the same edge the STOP->START transition pops.
        push_byte(8'h31, w);
        release_valid();
        wait_tx_low("t4_start");
        push_byte(8'h32, w);
        release_valid();
        repeat (FRAME - 4) @(negedge clk);
        check("t4_count_before", int'(fifo_count), 1);
        check("t4_stop_high", int'(tx), 1);
        push_byte(8'h33, w);
        release_valid();
        check("t4_count_same", int'(fifo_count), 1);
        check("t4_restart", int'(tx), 0);
        wait_idle("t4_idle", 1000);

        // Asynchronous reset during data bit 3 of 0xF0 with another byte still queued.
        push_byte(8'hF0, w);
        release_valid();
        wait_tx_low("t5_start");
        push_byte(8'h77, w);
        release_valid();
        repeat (68) @(negedge clk);
        check("t5_bit3_low", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx", int'(tx), 1);
        check("t5_rst_count", int'(fifo_count), 0);
        check("t5_rst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_after_busy", int'(busy), 0);
        check("t5_after_tx", int'(tx), 1);
        push_byte(8'h0F, w);
        release_valid();
        wait_idle("t5_idle", 400);
        check("t5_frame_len", t_done - t_first, FRAME);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07, w);
        release_valid();
        wait_idle("t6_idle_a", 400);
        check("t6_parity_07", int'(last_parity), 1);
        check("t6_frame_len", t_done - t_first, 11 * BIT);
        push_byte(8'h03, w);
        release_valid();
        wait_idle("t6_idle_b", 400);
        check("t6_parity_03", int'(last_parity), 0);
`endif

        repeat (4) @(negedge clk);
        check("rx_frames", rx_frames, NFRAMES);
        check("sb_empty", exp_q.size(), 0);
        check("ready_rule", ready_err, 0);
        check("max_count", max_cnt, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
